load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit for the RV32I core: accepts one load or store per request from the execute stage and drives a single-outstanding req/ack data-memory bus. Generates byte strobes and lane-replicated store data, then extracts and sign/zero-extends load data into the word the writeback mux selects on loads. Provides `busy` so the pipeline stalls while an access is in flight.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles `bus_req` may remain unacknowledged before the access is aborted with an error; minimum 1.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request from execute stage; accepted only in IDLE.
- `is_load` in 1: request is a load.
- `is_store` in 1: request is a store.
- `funct3` in 3: RV32I width/sign code; 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in 32: byte address.
- `store_data` in 32: store source; low byte or low half used for B/H.
- `busy` out 1: high from the accept edge until `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; misaligned access, illegal funct3, or timeout.
- `mem_r_data` out 32: extended load result; held from `done` until the next accept.
- `bus_req` out 1: memory request.
- `bus_we` out 1: 1 for store.
- `bus_addr` out 32: word-aligned address, `addr` with bits [1:0] = 0.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_wstrb` out 4: byte-enable strobes; 0000 on loads.
- `bus_ack` in 1: memory completes the request this cycle.
- `bus_rdata` in 32: read word; valid when `bus_ack` is high.

## Operation
- States: IDLE, REQ, RESP.
- IDLE → REQ: `req_valid` is high, exactly one of `is_load`/`is_store` is high, funct3 is legal for the operation, and the access passes the alignment check. All request fields are registered on this edge.
- IDLE → RESP with `err`=1: request accepted but rejected (both or neither op bit set, illegal funct3, stores with funct3 100/101, or a misaligned access when the trap is enabled). No bus activity occurs.
- REQ: `bus_req` is high and all bus outputs are held stable. `bus_ack` captures `bus_rdata` into the extractor → RESP.
  - The timeout counter increments on each REQ cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES`: → RESP with `err`=1 and `mem_r_data`=0.
- RESP: `done`=1 for one cycle → IDLE. A new request is accepted in IDLE no earlier than the cycle after `done`.
- Store strobes:
  - SB: `wstrb` = 0001 << addr[1:0]; `wdata` = byte replicated ×4.
  - SH: `wstrb` = 0011 << (2·addr[1]); `wdata` = half replicated ×2.
  - SW: `wstrb` = 1111.
- Load extraction:
  - Select the byte or half by addr[1:0].
  - B and H sign-extend; BU and HU zero-extend.
  - W passes the word through.
- Stores leave `mem_r_data` at 0.
- `err` is 0 on successful completion.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `mem_r_data`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_wstrb`=0, state IDLE, counter 0.
- Reset asserted mid-access drops `bus_req` on that edge. A later `bus_ack` is ignored.
- Minimum latency:
  - Accept at edge 0.
  - `bus_req` high in cycle 1.
  - Ack in cycle 1 gives `done` in cycle 2.
- Rejected request: `done` in cycle 1.
- `bus_ack` is ignored outside REQ.
- Ack and timeout in the same cycle: the ack wins and the access succeeds.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: an H access with addr[0]=1, or a W access with addr[1:0]≠0, completes with `err`=1 and no bus request.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Offending low address bits are forced to natural alignment (H clears bit 0; W clears bits [1:0]).
  - The access proceeds normally with no error.

## Structure
- `lsu_pkg` holds:
  - funct3 constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - the state enum.
  - the default for `TIMEOUT_CYCLES`.
- Sub-module `lsu_align`: purely combinational. Maps funct3 and addr[1:0] to `wstrb`/`wdata`, and maps `bus_rdata` to the extended load word. The FSM and timeout counter stay in `load_store_unit`.

## Test plan
- LB at addr 0x103, `bus_rdata` 0x80FF_1234, ack in cycle 1 → `done` in cycle 2, `mem_r_data` 0xFFFF_FF80, `bus_addr` 0x100, `err`=0.
- SH at addr 0x22, `store_data` 0x0000_ABCD → `bus_we`=1, `bus_wstrb` 1100, `bus_wdata` 0xABCD_ABCD, `bus_addr` 0x20.
- LHU at 0x40, ack delayed 5 cycles → `bus_req` high cycles 1–6, `busy` held, `done` cycle 7, `mem_r_data` = `bus_rdata`[15:0] zero-extended.
- LW with no ack and `TIMEOUT_CYCLES`=4 → `bus_req` drops after 4 cycles, `done`=1, `err`=1, `mem_r_data`=0.
- LW at 0x101:
  - Trap enabled → `done` in cycle 1, `err`=1, `bus_req` never asserted.
  - Trap disabled → `bus_addr` 0x100, `err`=0.
- `rst` asserted during REQ, ack arriving next cycle → outputs at reset values, no `done` pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states,
// the default bus timeout and the funct3 legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 32'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    // Unsigned widths only make sense for loads.
    function automatic logic f3_legal(input logic is_st, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_st;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes/replicated data from the
// request fields, and load extraction/extension from the returned bus word.
module lsu_align (
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);
    import lsu_pkg::*;

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store side: strobe pattern and lane replication by access width.
    always_comb begin
        wstrb = 4'b0000;
        wdata = 32'h0000_0000;
        case (st_funct3)
            F3_B: begin
                wstrb = 4'b0001 << st_addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                wstrb = 4'b0011 << {st_addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            F3_W: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
            default: begin
                wstrb = 4'b0000;
                wdata = 32'h0000_0000;
            end
        endcase
    end

    // Load side: pick the addressed lane, then sign- or zero-extend.
    always_comb begin
        byte_s    = rdata[{ld_addr_lo, 3'b000} +: 8];
        half_s    = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = 32'h0000_0000;
        case (ld_funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_data = {24'h00_0000, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_HU:   load_data = {16'h0000, half_s};
            F3_W:    load_data = rdata;
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-stage LSU with a single-outstanding req/ack bus and timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_r_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       ld_funct3_r;
    logic [1:0]       ld_addr_lo_r;
    logic             busy_r, done_r, err_r, bus_req_r, bus_we_r;
    logic [31:0]      mem_r_data_r, bus_addr_r, bus_wdata_r;
    logic [3:0]       bus_wstrb_r;

    logic             half_s, word_s, accept_ok_s;
    logic [1:0]       eff_lo_s;
    logic [3:0]       wstrb_s;
    logic [31:0]      wdata_s, load_data_s;

    // Request decode: legality and the effective low address bits.
    always_comb begin
        half_s = (funct3[1:0] == 2'b01);
        word_s = (funct3[1:0] == 2'b10);
`ifdef LSU_MISALIGN_TRAP_EN
        eff_lo_s    = addr[1:0];
        accept_ok_s = (is_load ^ is_store) && f3_legal(is_store, funct3)
                      && !((half_s && addr[0]) || (word_s && (addr[1:0] != 2'b00)));
`else
        accept_ok_s = (is_load ^ is_store) && f3_legal(is_store, funct3);
        if (word_s) begin
            eff_lo_s = 2'b00;
        end else if (half_s) begin
            eff_lo_s = {addr[1], 1'b0};
        end else begin
            eff_lo_s = addr[1:0];
        end
`endif
    end

    lsu_align u_align (
        .st_funct3  (funct3),
        .st_addr_lo (eff_lo_s),
        .store_data (store_data),
        .wstrb      (wstrb_s),
        .wdata      (wdata_s),
        .ld_funct3  (ld_funct3_r),
        .ld_addr_lo (ld_addr_lo_r),
        .rdata      (bus_rdata),
        .load_data  (load_data_s)
    );

    // Access FSM, timeout counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            ld_funct3_r  <= 3'b000;
            ld_addr_lo_r <= 2'b00;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            mem_r_data_r <= 32'h0000_0000;
            bus_req_r    <= 1'b0;
            bus_we_r     <= 1'b0;
            bus_addr_r   <= 32'h0000_0000;
            bus_wdata_r  <= 32'h0000_0000;
            bus_wstrb_r  <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        busy_r       <= 1'b1;
                        mem_r_data_r <= 32'h0000_0000;
                        cnt_r        <= '0;
                        if (accept_ok_s) begin
                            state_r      <= ST_REQ;
                            bus_req_r    <= 1'b1;
                            bus_we_r     <= is_store;
                            bus_addr_r   <= {addr[31:2], 2'b00};
                            bus_wstrb_r  <= is_store ? wstrb_s : 4'b0000;
                            bus_wdata_r  <= is_store ? wdata_s : 32'h0000_0000;
                            ld_funct3_r  <= funct3;
                            ld_addr_lo_r <= eff_lo_s;
                        end else begin
                            // Rejected requests complete without touching the bus.
                            state_r <= ST_RESP;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        state_r      <= ST_RESP;
                        bus_req_r    <= 1'b0;
                        done_r       <= 1'b1;
                        err_r        <= 1'b0;
                        mem_r_data_r <= bus_we_r ? 32'h0000_0000 : load_data_s;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r      <= ST_RESP;
                        bus_req_r    <= 1'b0;
                        done_r       <= 1'b1;
                        err_r        <= 1'b1;
                        mem_r_data_r <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bus_req_r <= 1'b0;
                    done_r    <= 1'b0;
                    err_r     <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign mem_r_data = mem_r_data_r;
    assign bus_req    = bus_req_r;
    assign bus_we     = bus_we_r;
    assign bus_addr   = bus_addr_r;
    assign bus_wdata  = bus_wdata_r;
    assign bus_wstrb  = bus_wstrb_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, random
// transactions against a behavioural model, timeout and reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_valid_to = 1'b0;
    logic        is_load = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0, store_data = 32'h0;
    logic        bus_ack = 1'b0, bus_ack_to = 1'b0;
    logic [31:0] bus_rdata = 32'h0, bus_rdata_to = 32'h0;

    logic        busy, done, err, bus_req, bus_we;
    logic [31:0] mem_r_data, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        busy_to, done_to, err_to, bus_req_to, bus_we_to;
    logic [31:0] mem_r_data_to, bus_addr_to, bus_wdata_to;
    logic [3:0]  bus_wstrb_to;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .err(err), .mem_r_data(mem_r_data), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst), .req_valid(req_valid_to), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy_to), .done(done_to),
        .err(err_to), .mem_r_data(mem_r_data_to), .bus_req(bus_req_to), .bus_we(bus_we_to),
        .bus_addr(bus_addr_to), .bus_wdata(bus_wdata_to), .bus_wstrb(bus_wstrb_to),
        .bus_ack(bus_ack_to), .bus_rdata(bus_rdata_to)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: byte-lane view of the access computed arithmetically.
    task automatic model(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                         output logic rej, output logic [31:0] baddr, output logic [3:0] strb,
                         output logic [31:0] wdata, output logic [31:0] mem);
        int size, off;
        bit legal, mis;
        longint val;
        size  = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        legal = (ld != st) && ((f3 <= 3'd2) || (ld && (f3 == 3'd4 || f3 == 3'd5)));
        off   = int'(a % 32'd4);
        mis   = (off % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
        rej = !legal || mis;
`else
        rej = !legal;
        off = off - (off % size);
`endif
        baddr = a - (a % 32'd4);
        strb  = 4'b0000;
        wdata = 32'h0;
        mem   = 32'h0;
        for (int i = 0; i < 4; i++) begin
            strb[i] = st && (i >= off) && (i < off + size);
            wdata[8*i +: 8] = sd[8*(i % size) +: 8];
        end
        if (ld) begin
            val = longint'((rd >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1));
            if (size < 4 && f3[2] == 1'b0 && val >= (64'd1 << (8 * size - 1)))
                val = val - (64'd1 << (8 * size));
            mem = val[31:0];
        end
    endtask

    // One full transaction on the main instance, ack arriving in cycle delay+1.
    task automatic run_txn(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                           input int delay, input logic exp_rej, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_mem);
        int req_cycles = 0, done_cyc = 0;
        logic got_err = 1'b0, got_we = 1'b0, busy_ok = 1'b1;
        logic [31:0] got_mem = 32'h0, got_addr = 32'h0, got_wdata = 32'h0;
        logic [3:0] got_strb = 4'b0000;
        @(negedge clk);
        req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 400 && done_cyc == 0; n++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (bus_req) begin
                if (req_cycles == 0 || n == delay + 1) begin
                    got_addr = bus_addr; got_strb = bus_wstrb; got_wdata = bus_wdata; got_we = bus_we;
                end
                req_cycles++;
            end
            if (done) begin
                done_cyc = n; got_err = err; got_mem = mem_r_data;
            end
            bus_ack   = bus_req && (n == delay + 1);
            bus_rdata = bus_ack ? rd : $urandom();
        end
        bus_ack = 1'b0;
        check({nm, " done_cycle"}, done_cyc, exp_rej ? 32'd1 : 32'(delay + 2));
        check({nm, " err"}, {31'd0, got_err}, {31'd0, exp_rej});
        check({nm, " req_cycles"}, req_cycles, exp_rej ? 32'd0 : 32'(delay + 1));
        check({nm, " busy_held"}, {31'd0, busy_ok}, 32'd1);
        if (!exp_rej) begin
            check({nm, " bus_addr"}, got_addr, exp_addr);
            check({nm, " bus_we"}, {31'd0, got_we}, {31'd0, st});
            check({nm, " bus_wstrb"}, {28'd0, got_strb}, {28'd0, exp_strb});
            if (st) check({nm, " bus_wdata"}, got_wdata, exp_wdata);
        end
        check({nm, " mem_r_data"}, got_mem, exp_rej ? 32'h0 : exp_mem);
        @(negedge clk);
        check({nm, " post_done"}, {30'd0, busy, done}, 32'd0);
        check({nm, " mem_held"}, mem_r_data, exp_rej ? 32'h0 : exp_mem);
    endtask

    // LW on the TIMEOUT_CYCLES=4 instance; ack_cyc of 0 means never acknowledge.
    task automatic run_to(input int ack_cyc, input logic [31:0] rd, output int req_cycles,
                          output int done_cyc, output logic got_err, output logic [31:0] got_mem);
        req_cycles = 0; done_cyc = 0; got_err = 1'b0; got_mem = 32'h0;
        @(negedge clk);
        req_valid_to = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h200;
        @(posedge clk);
        #1 req_valid_to = 1'b0;
        for (int n = 1; n <= 20 && done_cyc == 0; n++) begin
            @(negedge clk);
            if (bus_req_to) req_cycles++;
            if (done_to) begin
                done_cyc = n; got_err = err_to; got_mem = mem_r_data_to;
            end
            bus_ack_to   = (n == ack_cyc);
            bus_rdata_to = rd;
        end
        bus_ack_to = 1'b0;
    endtask

    typedef struct {
        logic ld, st; logic [2:0] f3; logic [31:0] a, sd, rd; int delay;
        logic rej; logic [31:0] baddr; logic [3:0] strb; logic [31:0] wdata, mem;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int rc, dc;
        logic e;
        logic [31:0] m;
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80};
        vecs[1]  = '{1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_ABCD, 32'h0, 0, 1'b0, 32'h20, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 3'b101, 32'h40, 32'h0, 32'h1234_F00D, 5, 1'b0, 32'h40, 4'b0000, 32'h0, 32'h0000_F00D};
        vecs[4]  = '{1'b0, 1'b1, 3'b000, 32'h7, 32'h0000_005A, 32'h0, 3, 1'b0, 32'h4, 4'b1000, 32'h5A5A_5A5A, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'h8001_7FFF, 0, 1'b0, 32'h10, 4'b0000, 32'h0, 32'hFFFF_8001};
        vecs[6]  = '{1'b1, 1'b0, 3'b100, 32'h1, 32'h0, 32'h0000_9C00, 2, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0000_009C};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h8, 32'h1234_5678, 32'h0, 1, 1'b0, 32'h8, 4'b1111, 32'h1234_5678, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 3'b100, 32'h0, 32'hFF, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[3]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'b001, 32'h13, 32'h0, 32'h7ABC_0000, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 3'b001, 32'h23, 32'h1111_BEEF, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
`else
        vecs[3]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 32'h100, 4'b0000, 32'h0, 32'hDEAD_BEEF};
        vecs[12] = '{1'b1, 1'b0, 3'b001, 32'h13, 32'h0, 32'h7ABC_0000, 0, 1'b0, 32'h10, 4'b0000, 32'h0, 32'h0000_7ABC};
        vecs[13] = '{1'b0, 1'b1, 3'b001, 32'h23, 32'h1111_BEEF, 32'h0, 0, 1'b0, 32'h20, 4'b1100, 32'hBEEF_BEEF, 32'h0};
`endif

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ctl", {27'd0, busy, done, err, bus_req, bus_we}, 32'd0);
        check("reset mem", mem_r_data, 32'h0);
        check("reset bus_addr", bus_addr, 32'h0);
        check("reset bus_wdata", bus_wdata, 32'h0);
        check("reset bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
        check("reset to ctl", {27'd0, busy_to, done_to, err_to, bus_req_to, bus_we_to}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].a,
                    vecs[i].sd, vecs[i].rd, vecs[i].delay, vecs[i].rej, vecs[i].baddr,
                    vecs[i].strb, vecs[i].wdata, vecs[i].mem);
        end

        // Ack on the last allowed cycle wins over the timeout.
        run_to(4, 32'hCAFE_0123, rc, dc, e, m);
        check("to_ack req_cycles", rc, 32'd4);
        check("to_ack done_cycle", dc, 32'd5);
        check("to_ack err", {31'd0, e}, 32'd0);
        check("to_ack mem", m, 32'hCAFE_0123);
        // No ack: abort after four request cycles with a zeroed result.
        run_to(0, 32'h5555_5555, rc, dc, e, m);
        check("to_none req_cycles", rc, 32'd4);
        check("to_none done_cycle", dc, 32'd5);
        check("to_none err", {31'd0, e}, 32'd1);
        check("to_none mem", m, 32'h0);

        // Reset during REQ, ack arriving the cycle after reset.
        run_txn("pre_rst", 1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h7777_1111, 0, 1'b0,
                32'h44, 4'b0000, 32'h0, 32'h7777_1111);
        @(negedge clk);
        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid req_before", {31'd0, bus_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid ctl", {27'd0, busy, done, err, bus_req, bus_we}, 32'd0);
        check("rst_mid mem", mem_r_data, 32'h0);
        check("rst_mid bus_addr", bus_addr, 32'h0);
        rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        bus_ack = 1'b0;
        check("rst_late_ack ctl", {27'd0, busy, done, err, bus_req, bus_we}, 32'd0);
        check("rst_late_ack mem", mem_r_data, 32'h0);

        // Random transactions against the model.
        for (int t = 0; t < 150; t++) begin
            logic ld, st, rj;
            logic [2:0] f3;
            logic [31:0] a, sd, rd, ba, wd, mm;
            logic [3:0] sb;
            int sel;
            sel = int'($urandom_range(0, 9));
            ld = (sel == 0) ? 1'b1 : ((sel == 1) ? 1'b0 : sel[0]);
            st = (sel == 0) ? 1'b1 : ((sel == 1) ? 1'b0 : ~sel[0]);
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom(); sd = $urandom(); rd = $urandom();
            model(ld, st, f3, a, sd, rd, rj, ba, sb, wd, mm);
            run_txn($sformatf("rnd%0d", t), ld, st, f3, a, sd, rd, int'($urandom_range(0, 6)),
                    rj, ba, sb, wd, mm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
